pipe_stage_reg: RTL and testbench

Generic parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer, flush and stall control, and per-stage throughput counters. It replaces the hand-written IF/ID, ID/EX, EX/LS and LS/WB pipe registers in the core, with the payload (control, operands, diff PC/instruction) packed into one `DATA_W` vector by the instantiating level. With `SKID=1` the upstream ready is fully registered, so no combinational ready path crosses the stage.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_stage_cnt.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 180 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types for the generic pipeline stage register.
//
//   stage_st_e : occupancy state of one stage
//                ST_EMPTY - nothing held
//                ST_BUSY  - main entry valid
//                ST_FULL  - main and skid entries valid (SKID=1 only)
//   OCC_W      : width of the occupancy count output
//   occ_of()   : maps a state to the number of entries it holds
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_st_e;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] occ_of(input stage_st_e st);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_cnt.sv
// ---------------------------------------------------------------------------
// pipe_stage_cnt
//   Free-running event counter that wraps modulo 2^CNT_W. Used for the
//   per-stage transfer and stall statistics.
//
//   Ports:
//     i_clk  in  1      clock, rising edge
//     i_rst  in  1      synchronous active-high reset, clears the count
//     i_inc  in  1      add one this cycle
//     o_cnt  out CNT_W  current count
// ---------------------------------------------------------------------------
module pipe_stage_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Plain binary add; the carry out of the MSB is dropped, which gives the
  // wrap-around behaviour.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register with valid/ready handshake. The caller
//   packs its whole payload into one DATA_W vector.
//
//   SKID=1 : two entries (main + skid). o_ready is a flop, so there is no
//            combinational path from i_ready/i_stall to o_ready. When the
//            downstream stops, one extra beat is absorbed into the skid entry
//            and o_ready drops one cycle later.
//   SKID=0 : single entry, o_ready is combinational from the downstream side.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_EMPTY | no entry held, o_valid=0
//   ST_BUSY  | main entry valid, presented on o_data
//   ST_FULL  | main and skid valid, upstream blocked (SKID=1 only)
//
//   Ports:
//     i_clk        in  1       clock, rising edge
//     i_rst        in  1       synchronous active-high reset
//     i_flush      in  1       drop all held entries, highest priority
//     i_stall      in  1       hold the downstream transfer this cycle
//     i_valid      in  1       upstream payload valid
//     o_ready      out 1       stage accepts upstream payload
//     i_data       in  DATA_W  upstream payload
//     o_valid      out 1       downstream payload valid
//     i_ready      in  1       downstream accepts
//     o_data       out DATA_W  downstream payload (main entry)
//     o_occ        out 2       entries held (0..2)
//     o_xfer_cnt   out CNT_W   completed downstream transfers (wraps)
//     o_stall_cnt  out CNT_W   cycles valid without a transfer (wraps)
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [OCC_W-1:0]  o_occ,
  output logic [CNT_W-1:0]  o_xfer_cnt,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  stage_st_e         state_q;
  stage_st_e         state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              ready;
  logic              in_fire;
  logic              out_fire;
  logic              stall_evt;

  assign o_valid = (state_q != ST_EMPTY);
  assign o_ready = ready;
  assign o_data  = main_q;
  assign o_occ   = occ_of(state_q);

  // Flush blocks both sides of the handshake in the same cycle.
  assign in_fire   = i_valid & ready & ~i_flush;
  assign out_fire  = o_valid & i_ready & ~i_stall & ~i_flush;
  assign stall_evt = o_valid & ~(i_ready & ~i_stall) & ~i_flush;

  // -------------------------------------------------------------------------
  // Next-state / data path
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_load = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = i_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = i_data;
        end else if (in_fire && (SKID != 0)) begin
          // Downstream did not take main: park the new beat behind it.
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // o_ready is low here, so only the downstream side can move.
        if (out_fire) begin
          main_d  = skid_data;
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Flush only clears validity; payload registers keep their contents.
    if (i_flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // -------------------------------------------------------------------------
  // Ready generation and skid entry
  // -------------------------------------------------------------------------
  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;

    // Ready looks ahead at the next state so it is already low in the
    // cycle the stage sits FULL.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        skid_q  <= '0;
        ready_q <= 1'b0;
      end else begin
        if (skid_load) begin
          skid_q <= i_data;
        end
        ready_q <= (state_d != ST_FULL);
      end
    end

    assign skid_data = skid_q;
    assign ready     = ready_q;
  end else begin : g_single
    logic unused_skid_load;

    assign ready            = ~i_rst & (~o_valid | (i_ready & ~i_stall));
    assign skid_data        = '0;
    assign unused_skid_load = skid_load;
  end

  // -------------------------------------------------------------------------
  // Performance counters (not cleared by flush)
  // -------------------------------------------------------------------------
  pipe_stage_cnt #(
    .CNT_W (CNT_W)
  ) u_xfer_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (out_fire),
    .o_cnt (o_xfer_cnt)
  );

  pipe_stage_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (stall_evt),
    .o_cnt (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic          rst1, flush1, stall1, valid1, rdy1;
  logic [DW-1:0] data1;
  logic          ordy1, ovld1;
  logic [DW-1:0] odata1;
  logic [1:0]    occ1;
  logic [31:0]   xfer1, stc1;

  // SKID=0 instance with 4-bit counters
  logic          rst0, flush0, stall0, valid0, rdy0;
  logic [DW-1:0] data0;
  logic          ordy0, ovld0;
  logic [DW-1:0] odata0;
  logic [1:0]    occ0;
  logic [3:0]    xfer0, stc0;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(32)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_flush(flush1), .i_stall(stall1),
    .i_valid(valid1), .o_ready(ordy1), .i_data(data1),
    .o_valid(ovld1), .i_ready(rdy1), .o_data(odata1),
    .o_occ(occ1), .o_xfer_cnt(xfer1), .o_stall_cnt(stc1)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst0), .i_flush(flush0), .i_stall(stall0),
    .i_valid(valid0), .o_ready(ordy0), .i_data(data0),
    .o_valid(ovld0), .i_ready(rdy0), .o_data(odata0),
    .o_occ(occ0), .o_xfer_cnt(xfer0), .o_stall_cnt(stc0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string         nm;
    logic          rst, flush, stall, valid, rdy;
    logic [DW-1:0] data;
    logic          e_valid, e_ready;
    logic [1:0]    e_occ;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic rst, input logic flush,
                              input logic stall, input logic valid, input logic rdy,
                              input logic [DW-1:0] d, input logic ev, input logic er,
                              input logic [1:0] eo, input logic [DW-1:0] ed);
    vec_t v;
    v.nm = nm; v.rst = rst; v.flush = flush; v.stall = stall; v.valid = valid;
    v.rdy = rdy; v.data = d; v.e_valid = ev; v.e_ready = er; v.e_occ = eo;
    v.e_data = ed;
    return v;
  endfunction

  // Inputs are applied, one edge passes, then the registered outputs of the
  // SKID=1 instance are compared.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst1 = vecs[i].rst; flush1 = vecs[i].flush; stall1 = vecs[i].stall;
      valid1 = vecs[i].valid; rdy1 = vecs[i].rdy; data1 = vecs[i].data;
      tick();
      chk({vecs[i].nm, "_valid"}, {31'd0, ovld1}, {31'd0, vecs[i].e_valid});
      chk({vecs[i].nm, "_ready"}, {31'd0, ordy1}, {31'd0, vecs[i].e_ready});
      chk({vecs[i].nm, "_occ"},   {30'd0, occ1},  {30'd0, vecs[i].e_occ});
      chk({vecs[i].nm, "_data"},  {16'd0, odata1}, {16'd0, vecs[i].e_data});
    end
  endtask

  initial begin
    rst1 = 1'b1; flush1 = 1'b0; stall1 = 1'b0; valid1 = 1'b0; rdy1 = 1'b0; data1 = '0;
    rst0 = 1'b1; flush0 = 1'b0; stall0 = 1'b0; valid0 = 1'b0; rdy0 = 1'b0; data0 = '0;

    //                 name    rst fl st va rd data      ev er occ  edata
    // 0..3 reset held 3 cycles with valid high, then release
    vecs.push_back(mk("rst_a", 1, 0, 0, 1, 1, 16'h0055, 0, 0, 2'd0, 16'h0000));
    vecs.push_back(mk("rst_b", 1, 0, 0, 1, 1, 16'h0055, 0, 0, 2'd0, 16'h0000));
    vecs.push_back(mk("rst_c", 1, 0, 0, 1, 1, 16'h0055, 0, 0, 2'd0, 16'h0000));
    vecs.push_back(mk("rel",   0, 0, 0, 0, 1, 16'h0000, 0, 1, 2'd0, 16'h0000));
    // 4..9 backpressure: A accepted, B absorbed into skid, C held upstream
    vecs.push_back(mk("bp_a",  0, 0, 0, 1, 1, 16'h000A, 1, 1, 2'd1, 16'h000A));
    vecs.push_back(mk("bp_b",  0, 0, 0, 1, 0, 16'h000B, 1, 0, 2'd2, 16'h000A));
    vecs.push_back(mk("bp_hd", 0, 0, 0, 1, 0, 16'h000C, 1, 0, 2'd2, 16'h000A));
    vecs.push_back(mk("bp_o1", 0, 0, 0, 1, 1, 16'h000C, 1, 1, 2'd1, 16'h000B));
    vecs.push_back(mk("bp_o2", 0, 0, 0, 1, 1, 16'h000C, 1, 1, 2'd1, 16'h000C));
    vecs.push_back(mk("bp_o3", 0, 0, 0, 0, 1, 16'h0000, 0, 1, 2'd0, 16'h000C));
    // 10..13 flush while FULL with a beat offered
    vecs.push_back(mk("fl_1",  0, 0, 0, 1, 0, 16'h00E1, 1, 1, 2'd1, 16'h00E1));
    vecs.push_back(mk("fl_2",  0, 0, 0, 1, 0, 16'h00E2, 1, 0, 2'd2, 16'h00E1));
    vecs.push_back(mk("fl_f",  0, 1, 0, 1, 1, 16'h00E3, 0, 1, 2'd0, 16'h00E1));
    vecs.push_back(mk("fl_af", 0, 0, 0, 0, 1, 16'h0000, 0, 1, 2'd0, 16'h00E1));
    // 14..16 reset in the middle of operation
    vecs.push_back(mk("mr_ld", 0, 0, 0, 1, 0, 16'h00F0, 1, 1, 2'd1, 16'h00F0));
    vecs.push_back(mk("mr_rs", 1, 0, 0, 1, 1, 16'h0077, 0, 0, 2'd0, 16'h0000));
    vecs.push_back(mk("mr_rl", 0, 0, 0, 0, 1, 16'h0000, 0, 1, 2'd0, 16'h0000));

    // ---- reset ----
    run_vecs(0, 3);
    chk("rst_xfer",  xfer1, 32'd0);
    chk("rst_stall", stc1,  32'd0);

    // ---- streaming 1..16, 1-cycle latency, one per cycle ----
    for (int i = 1; i <= 16; i++) begin
      valid1 = 1'b1; data1 = DW'(i); rdy1 = 1'b1;
      tick();
      chk($sformatf("str_data%0d", i), {16'd0, odata1}, i);
      chk($sformatf("str_valid%0d", i), {31'd0, ovld1}, 32'd1);
      chk($sformatf("str_ready%0d", i), {31'd0, ordy1}, 32'd1);
    end
    valid1 = 1'b0;
    tick();
    chk("str_drain", {31'd0, ovld1}, 32'd0);
    chk("str_xfer",  xfer1, 32'd16);
    chk("str_stall", stc1,  32'd0);

    // ---- backpressure ----
    run_vecs(4, 9);
    chk("bp_xfer",  xfer1, 32'd19);
    chk("bp_stall", stc1,  32'd2);

    // ---- stall: 4 cycles with valid and downstream ready ----
    rst1 = 1'b1; valid1 = 1'b0; rdy1 = 1'b1;
    tick();
    rst1 = 1'b0;
    tick();
    valid1 = 1'b1; data1 = 16'h00D0;
    tick();
    valid1 = 1'b0; stall1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stl_valid%0d", i), {31'd0, ovld1}, 32'd1);
      chk($sformatf("stl_data%0d", i), {16'd0, odata1}, 32'h00D0);
    end
    chk("stl_cnt",  stc1,  32'd4);
    chk("stl_xfer", xfer1, 32'd0);
    stall1 = 1'b0;
    tick();
    chk("stl_rel_valid", {31'd0, ovld1}, 32'd0);
    chk("stl_rel_xfer",  xfer1, 32'd1);

    // ---- flush ----
    run_vecs(10, 13);
    chk("fl_xfer",  xfer1, 32'd1);
    chk("fl_stall", stc1,  32'd5);

    // ---- reset mid-operation ----
    run_vecs(14, 16);
    chk("mr_xfer",  xfer1, 32'd0);
    chk("mr_stall", stc1,  32'd0);

    // ---- SKID=0, 4-bit counter wrap, ready toggling ----
    valid0 = 1'b1; rdy0 = 1'b1;
    #1;
    chk("s0_rst_ready", {31'd0, ordy0}, 32'd0);
    tick();
    rst0 = 1'b0;
    begin
      int beat;
      beat = 1;
      for (int c = 0; c < 34; c++) begin
        valid0 = 1'b1; data0 = DW'(beat); rdy0 = c[0];
        #1;
        // Empty at c=0; afterwards always holding, so ready follows i_ready.
        chk($sformatf("s0_ready%0d", c), {31'd0, ordy0}, (c == 0) ? 32'd1 : {31'd0, c[0]});
        @(posedge clk);
        #1;
        if (c == 0 || c[0]) begin
          chk($sformatf("s0_data%0d", c), {16'd0, odata0}, beat);
          beat++;
        end
      end
    end
    chk("s0_valid", {31'd0, ovld0}, 32'd1);
    chk("s0_xfer_wrap",  {28'd0, xfer0}, 32'd1);
    chk("s0_stall_wrap", {28'd0, stc0},  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
